// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin owner sequencer for a shared 8:1 mux datapath.
// One requester owns the mux for up to BURST accepted beats. Ownership rotates
// when the burst is used up or when the owner drops its request. A new owner
// is chosen on the same edge, so there is no dead cycle between owners.
`timescale 1ns/1ps
module rr_arbiter8 #(
    parameter int BURST = 4,
    parameter int CNTW  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out_valid,
    output logic [7:0] ack,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_sel;
    logic [7:0]        r_grant;
    logic              r_busy;
    logic [CNTW-1:0]   r_beat_cnt;
    logic [2:0]        r_ptr;

    logic              w_beat;
    logic              w_withdraw;
    logic              w_burst_done;
    logic              w_release;
    logic [2:0]        w_arb_ptr;
    logic [7:0]        w_arb_req;
    logic              w_win_found;
    logic [2:0]        w_win_idx;

    // Scan from p upward (mod 8) and return {found, index} of the first set bit.
    // The loop runs downward so that the candidate closest to p is written last and wins.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign sel       = r_sel;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign out_valid = r_busy & req[r_sel];
    assign ack       = r_grant & {8{w_beat}};

    // Work out the release conditions and the next winner.
    // NOTE: every signal assigned here gets a default first. A path that leaves
    // a signal unassigned would make synthesis infer a latch.
    always_comb begin
        w_beat       = out_valid & out_ready;
        w_withdraw   = r_busy & ~req[r_sel];
        w_burst_done = w_beat & (r_beat_cnt == CNTW'(BURST - 1));
        w_release    = w_withdraw | w_burst_done;
        w_arb_ptr    = r_ptr;
        w_arb_req    = req;
        if (w_release) begin
            // On release, priority moves past the owner that is leaving.
            w_arb_ptr = r_sel + 3'd1;
            if (w_withdraw) w_arb_req[r_sel] = 1'b0;
        end
        {w_win_found, w_win_idx} = pick(w_arb_req, w_arb_ptr);
    end

    // Owner state machine: grant on IDLE->BUSY, count beats, and rotate on release.
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // here is small control state, so each one is reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_found) begin
                        r_state    <= BUSY;
                        r_busy     <= 1'b1;
                        r_sel      <= w_win_idx;
                        r_grant    <= 8'(1) << w_win_idx;
                        r_beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_ptr <= r_sel + 3'd1;
                        if (w_win_found) begin
                            r_sel      <= w_win_idx;
                            r_grant    <= 8'(1) << w_win_idx;
                            r_beat_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_grant <= '0;
                        end
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed test of rr_arbiter8 with BURST=4. Outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic [7:0] ack;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter8 #(.BURST(4), .CNTW(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Check that the owner is idx and that a beat is accepted this cycle.
    task automatic check_owner(input string tag, input int idx);
        logic [7:0] oh;
        oh = 8'(1) << idx;
        check({tag, ".grant"}, grant, oh);
        check({tag, ".sel"}, {5'd0, sel}, 8'(idx));
        check({tag, ".ack"}, ack, oh);
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b1;

        // 1: while reset is held, every output stays clear even with all requests high
        repeat (3) tick;
        check("rst.grant", grant, 8'h00);
        check("rst.sel", {5'd0, sel}, 8'h00);
        check("rst.busy", {7'd0, busy}, 8'h00);
        check("rst.valid", {7'd0, out_valid}, 8'h00);
        check("rst.ack", ack, 8'h00);
        reset_n = 1'b1;
        tick;

        // 2: rotation over owners 0..7 and back to 0, 4 beats each with no gap
        for (int k = 0; k < 36; k++) begin
            check_owner($sformatf("rot%0d", k), (k / 4) % 8);
            tick;
        end
        // Owner 1 now has beat_cnt=0

        // 3: owner 1 withdraws; only req[5] remains
        req = 8'h20;
        #1;
        check("wd.valid_drop", {7'd0, out_valid}, 8'h00);
        check("wd.ack_drop", ack, 8'h00);
        tick;
        check_owner("wd.b0", 5);
        tick;
        check_owner("wd.b1", 5);
        tick;
        req = 8'h00;
        #1;
        check("wd.ack_off", ack, 8'h00);
        tick;
        check("wd.idle_grant", grant, 8'h00);
        check("wd.idle_busy", {7'd0, busy}, 8'h00);
        req = 8'h41;
        tick;
        check_owner("wd.ptr6", 6);

        // 4: owner 6 withdraws and owner 3 wins (ptr=7). It is then held off for 10 cycles.
        req       = 8'h18;
        out_ready = 1'b0;
        #1;
        check("bp.ack_wd", ack, 8'h00);
        tick;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp.hold%0d.grant", i), grant, 8'h08);
            check($sformatf("bp.hold%0d.ack", i), ack, 8'h00);
            tick;
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_owner($sformatf("bp.beat%0d", i), 3);
            tick;
        end
        check_owner("bp.rotate", 4);

        // 5: sole requester 2 is granted bursts back to back
        req = 8'h04;
        #1;
        check("sole.ack_wd", ack, 8'h00);
        tick;
        for (int i = 0; i < 14; i++) begin
            check_owner($sformatf("sole%0d", i), 2);
            tick;
        end
        // beat_cnt is now 2 (mid-burst)

        // 6: asynchronous reset between edges, then arbitration restarts from ptr=0
        req = 8'h12;
        #2;
        reset_n = 1'b0;
        #1;
        check("ar.grant", grant, 8'h00);
        check("ar.sel", {5'd0, sel}, 8'h00);
        check("ar.busy", {7'd0, busy}, 8'h00);
        check("ar.ack", ack, 8'h00);
        tick;
        tick;
        check("ar.held_grant", grant, 8'h00);
        reset_n = 1'b1;
        tick;
        check_owner("ar.restart", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
